// File: rtl/uart_rx.sv
// UART 8N1 receiver with first-word-fall-through receive buffer and sticky error flags.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 50,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rd_data,
    output logic       rd_valid,
`ifdef UART_RX_FIFO_EN
    output logic [$clog2(FIFO_DEPTH):0] count,
`else
    output logic [0:0] count,
`endif
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CW      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned FULL_M1 = CLKS_PER_BIT - 1;
    localparam int unsigned HALF_M1 = (CLKS_PER_BIT / 2) - 1;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_rx: FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_meta_q, rxs_q;
    logic          push, frame_set, drop;
    logic          frame_err_q, frame_err_d, overrun_q, overrun_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Stop sample returns straight to IDLE so a start bit right behind it is not missed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CW'(HALF_M1)) begin
                    cnt_d   = '0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(FULL_M1)) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CW'(FULL_M1)) begin
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                    push      = rxs_q;
                    frame_set = !rxs_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Setting a flag takes priority over a clear arriving in the same cycle.
    always_comb begin
        frame_err_d = frame_set | (frame_err_q & ~clr_err);
        overrun_d   = drop | (overrun_q & ~clr_err);
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

`ifdef UART_RX_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          empty, full, do_pop, do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign do_pop  = rd_en && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;
`else
    logic [7:0] hold_q;
    logic       full_q, full_d;
    logic       do_pop, do_push;

    assign do_pop  = rd_en && full_q;
    assign do_push = push && (!full_q || do_pop);
    assign drop    = push && full_q && !do_pop;

    always_comb begin
        full_d = full_q;
        if (do_push)     full_d = 1'b1;
        else if (do_pop) full_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) hold_q <= shift_q;
            full_q <= full_d;
        end
    end

    assign rd_valid = full_q;
    assign rd_data  = full_q ? hold_q : '0;
    assign count    = full_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, directed corner cases and
// randomized traffic checked against a queue model. Follows UART_RX_FIFO_EN like the DUT.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CPB = 50;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 1;
`endif

    logic                      clk = 1'b0;
    logic                      reset, rx, rd_en, clr_err;
    logic [7:0]                rd_data;
    logic                      rd_valid;
    logic [$clog2(DEPTH):0]    count;
    logic                      frame_err, overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mq[$];
    logic       m_fe, m_ov;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[8];

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "/count"}, int'(count), mq.size());
        check({tag, "/rd_valid"}, int'(rd_valid), int'(mq.size() > 0));
        check({tag, "/frame_err"}, int'(frame_err), int'(m_fe));
        check({tag, "/overrun"}, int'(overrun), int'(m_ov));
        if (mq.size() > 0) check({tag, "/rd_data"}, int'(rd_data), int'(mq[0]));
    endtask

    // Whole frame; the model is updated between the two checks around the stop mid-point.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
        rx = stop;
        tick(20);
        check("pre_stop_count", int'(count), mq.size());
        if (stop) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ov = 1'b1;
        end else begin
            m_fe = 1'b1;
        end
        tick(20);
        check_state("post_stop");
        tick(CPB - 40);
        rx = 1'b1;
        if (!stop) tick(2 * CPB);
    endtask

    task automatic pop();
        check_state("pre_pop");
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        tick(1);
    endtask

    task automatic clear();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        tick(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/rd_valid"}, int'(rd_valid), 0);
        check({tag, "/count"}, int'(count), 0);
        check({tag, "/rd_data"}, int'(rd_data), 0);
        check({tag, "/frame_err"}, int'(frame_err), 0);
        check({tag, "/overrun"}, int'(overrun), 0);
    endtask

    initial begin
        reset = 1'b0;
        rx = 1'b1;
        rd_en = 1'b0;
        clr_err = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b1;
        tick(5);

        vecs[0] = '{data: 8'h2D, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h2D, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'hA5, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};
        vecs[2] = '{data: 8'h5A, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h5A, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h00, exp_ferr: 1'b0};
        vecs[4] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};
        vecs[5] = '{data: 8'h80, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h80, exp_ferr: 1'b0};
        vecs[6] = '{data: 8'h01, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h01, exp_ferr: 1'b0};
        vecs[7] = '{data: 8'hC3, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};

        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].data, vecs[v].stop);
            check("vec_valid", int'(rd_valid), int'(vecs[v].exp_valid));
            check("vec_ferr", int'(frame_err), int'(vecs[v].exp_ferr));
            check("vec_overrun", int'(overrun), 0);
            if (vecs[v].exp_valid) begin
                check("vec_data", int'(rd_data), int'(vecs[v].exp_data));
                check("vec_count", int'(count), 1);
                pop();
            end
            if (vecs[v].exp_ferr) begin
                clear();
                check("clr_ferr", int'(frame_err), 0);
            end
        end

        // Short low pulse on an idle line must be rejected without flags.
        rx = 1'b0;
        tick(10);
        rx = 1'b1;
        tick(2 * CPB);
        check_state("glitch");
        send_frame(8'h3C, 1'b1);
        check("glitch_next_data", int'(rd_data), 8'h3C);
        pop();

        pop();
        check("empty_rd_count", int'(count), 0);
        send_frame(8'h77, 1'b1);
        check("after_empty_rd_data", int'(rd_data), 8'h77);
        pop();

`ifdef UART_RX_FIFO_EN
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
        check("full_count", int'(count), 16);
        check("full_overrun", int'(overrun), 1);
        for (int i = 0; i < 16; i++) begin
            check("drain_data", int'(rd_data), i);
            pop();
        end
        check("drain_valid", int'(rd_valid), 0);
        clear();
`else
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("hold_data", int'(rd_data), 8'h11);
        check("hold_overrun", int'(overrun), 1);
        pop();
        check("hold_valid", int'(rd_valid), 0);
        clear();
`endif

        // Reset in the middle of data bit 4, with a byte buffered and a flag set.
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b0);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            tick(CPB);
        end
        tick(CPB / 2);
        reset = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        mq.delete();
        m_fe = 1'b0;
        m_ov = 1'b0;
        tick(10);
        reset = 1'b1;
        tick(2 * CPB);
        check_state("post_reset_idle");
        send_frame(8'h81, 1'b1);
        check("post_reset_data", int'(rd_data), 8'h81);
        pop();

        for (int it = 0; it < 40; it++) begin
            logic [7:0] d;
            logic       s;
            d = 8'($urandom);
            s = ($urandom_range(0, 7) != 0);
            send_frame(d, s);
            for (int r = $urandom_range(0, 2); r > 0; r--) pop();
            if ($urandom_range(0, 5) == 0) begin
                clear();
                check_state("rand_clear");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 50, meaning clk cycles per UART bit (500 ns at 100 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries; must be a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port rd_en, input, 1, pop request for the head byte.
REQ-007 SHALL have port clr_err, input, 1, one-cycle pulse that clears the sticky error flags.
REQ-008 SHALL have port rd_data, output, 8, the FIFO head byte (first-word fall-through).
REQ-009 SHALL have port rd_valid, output, 1, asserted while the FIFO is not empty.
REQ-010 SHALL have port count, output, $clog2(FIFO_DEPTH)+1, the number of bytes held.
REQ-011 SHALL have port frame_err, output, 1, sticky flag for a bad stop bit.
REQ-012 SHALL have port overrun, output, 1, sticky flag for a byte dropped while the FIFO was full.

Function
REQ-013 SHALL synchronise rx through 2 flip-flops that reset to 1; all decisions use the synchronised value rxs.
REQ-014 SHALL use frame format 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-015 SHALL implement the FSM IDLE -> START on rxs==0; bit counter loaded.
REQ-016 START: after CLKS_PER_BIT/2 cycles, sample rxs; if 0 go to DATA, if 1 return to IDLE (glitch reject, no flags).
REQ-017 DATA: every CLKS_PER_BIT cycles, shift rxs into bit[i], i=0..7; after bit 7 go to STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles, sample rxs, then go to IDLE in the same cycle so a back-to-back start bit is caught.
REQ-019 Stop sample 1: push the byte; rd_valid is high the cycle after the stop sample.
REQ-020 Stop sample 0: discard the byte and set frame_err.
REQ-021 Push when full and no rd_en in that cycle: drop the byte, set overrun, keep FIFO contents.
REQ-022 Push and rd_en in the same cycle when full: both happen, overrun unchanged, count unchanged.
REQ-023 Push and rd_en in the same cycle when empty: rd_en is ignored; the byte is stored and count becomes 1.
REQ-024 rd_en while empty SHALL be ignored, with no pointer change.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count saturates at FIFO_DEPTH.
REQ-026 clr_err SHALL clear both flags; if an error occurs in the same cycle, set wins.

Reset
REQ-027 reset low SHALL immediately force: FSM IDLE, sync flops 1, FIFO empty, count 0, rd_valid 0, rd_data 0, frame_err 0, overrun 0.
REQ-028 Reset mid-frame SHALL abandon the partial byte; after release, the next falling edge is a fresh start bit.

Configuration
REQ-029 Macro UART_RX_FIFO_EN defined: FIFO of FIFO_DEPTH entries as specified above.
REQ-030 UART_RX_FIFO_EN undefined: single holding register, effective depth 1, count width 1, FIFO_DEPTH ignored; all full/overrun rules apply with depth 1.

Verification
REQ-031 Send 0x2D at CLKS_PER_BIT=50 -> rd_valid rises 1 cycle after the stop mid-sample; rd_data=0x2D; count=1; flags 0.
REQ-032 Send 17 bytes 0x00..0x10 back-to-back with no reads (FIFO_EN) -> count=16, overrun=1, reads return 0x00..0x0F in order, then rd_valid=0.
REQ-033 Frame 0xA5 with stop bit driven 0 -> frame_err=1, count unchanged; clr_err pulse -> frame_err=0; next frame 0x5A is received correctly.
REQ-034 rx low for 10 cycles then high -> FSM returns to IDLE, no byte, no flags; a following 0x3C is received correctly.
REQ-035 Assert reset low at data bit 4 of 0xFF -> all outputs at reset values immediately; after release, 0x81 is received correctly.
REQ-036 Without UART_RX_FIFO_EN, send 0x11 then 0x22 with no read -> rd_data=0x11, overrun=1; rd_en -> rd_valid=0.
